// File: rtl/dm_port_arbiter.sv
// Two-master arbiter in front of the single-port data memory.
// M0 has priority, M1 is promoted after waiting, and locked bursts are length-capped.
module dm_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned WCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             m0_rvalid_q, m1_rvalid_q, err_q;
  logic [31:0]      m0_rdata_q, m1_rdata_q;
  logic             win0, win1, sel_we, sel_lock, be_ok;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                            be_legal = 1'b0;
    endcase
  endfunction

  // Winner selection, next state and the DM-side mux.
  always_comb begin
    win0       = 1'b0;
    win1       = 1'b0;
    state_d    = IDLE;
    lock_cnt_d = '0;
    wait_cnt_d = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    sel_we     = 1'b0;
    sel_lock   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m1_req && (!m0_req || wait_cnt_q == WCW'(STARVE_LIMIT))) win1 = 1'b1;
        else if (m0_req)                                             win0 = 1'b1;
      end
      LOCK0:   win0 = m0_req;
      LOCK1:   win1 = m1_req;
      default: ;
    endcase

    // Nothing is granted while reset is asserted.
    if (!reset) begin
      win0 = 1'b0;
      win1 = 1'b0;
    end

    if (win0) begin
      mem_addr   = m0_addr;
      mem_wdata  = m0_wdata;
      mem_byteen = m0_be;
      sel_we     = m0_we;
      sel_lock   = m0_lock;
    end else if (win1) begin
      mem_addr   = m1_addr;
      mem_wdata  = m1_wdata;
      mem_byteen = m1_be;
      sel_we     = m1_we;
      sel_lock   = m1_lock;
    end

    be_ok  = be_legal(mem_byteen);
    mem_we = sel_we & be_ok & (mem_byteen != 4'b0000);

    // The grant that would bring the burst to LOCK_MAX ignores lock.
    if ((win0 || win1) && sel_lock && (lock_cnt_q != LCW'(LOCK_MAX - 1))) begin
      state_d    = win0 ? LOCK0 : LOCK1;
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end

    if (m1_req && !win1)
      wait_cnt_d = (wait_cnt_q == WCW'(STARVE_LIMIT)) ? wait_cnt_q : wait_cnt_q + WCW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= win0 & ~m0_we;
      m1_rvalid_q <= win1 & ~m1_we;
      err_q       <= (win0 | win1) & ~be_ok;
      if (win0 && !m0_we) m0_rdata_q <= mem_rdata;
      if (win1 && !m1_we) m1_rdata_q <= mem_rdata;
    end
  end

  assign m0_gnt    = win0;
  assign m1_gnt    = win1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed and random stimulus for dm_port_arbiter, checked against a behavioural
// arbitration model and a shadow copy of the data memory.
module tb_dm_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_MAX     = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, err;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_byteen(mem_byteen), .mem_rdata(mem_rdata), .err(err)
  );

  function automatic logic [31:0] seed(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Data memory stub: combinational read, byte-enabled write on posedge.
  logic [31:0] dm [64];
  assign mem_rdata = dm[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dm[i] <= seed(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteen[b]) dm[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          owner, burst, waited, last_w;
  logic [31:0] shadow [64];
  logic        e_rv0, e_rv1, e_err;
  logic [31:0] e_rd0, e_rd1;
  logic        g0_seen, g1_seen, we_seen;
  logic [3:0]  be_seen;
  logic [3:0]  legal_tab [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  function automatic bit legal(input logic [3:0] be);
    return be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; burst = 0; waited = 0; last_w = -1;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0; e_rd0 = '0; e_rd1 = '0;
    for (int i = 0; i < 64; i++) shadow[i] = seed(i);
  endtask

  // Who gets the memory this cycle: the lock owner only, otherwise M0 unless M1 starved.
  function automatic int pick();
    if (owner == 0) return m0_req ? 0 : -1;
    if (owner == 1) return m1_req ? 1 : -1;
    if (m1_req && (!m0_req || waited >= STARVE_LIMIT)) return 1;
    if (m0_req) return 0;
    return -1;
  endfunction

  task automatic set_m(input int k, input logic req, input logic we, input logic lock,
                       input logic [5:0] idx, input logic [31:0] wd, input logic [3:0] be);
    if (k == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = {24'h0, idx, 2'b00};
      m0_wdata = wd; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = {24'h0, idx, 2'b00};
      m1_wdata = wd; m1_be = be;
    end
  endtask

  // One cycle: check all outputs against the model, then advance the model.
  task automatic step();
    int          w;
    logic [31:0] a, d;
    logic [3:0]  b;
    logic        wr, lk;
    #1;
    w = pick();
    a = '0; d = '0; b = '0; wr = 1'b0; lk = 1'b0;
    if (w == 0) begin a = m0_addr; d = m0_wdata; b = m0_be; wr = m0_we; lk = m0_lock; end
    if (w == 1) begin a = m1_addr; d = m1_wdata; b = m1_be; wr = m1_we; lk = m1_lock; end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("err", 32'(err), 32'(e_err));
    chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    chk("mem_byteen", 32'(mem_byteen), 32'(b));
    chk("mem_we", 32'(mem_we), 32'(wr && legal(b) && b != 4'b0000));
    g0_seen = m0_gnt; g1_seen = m1_gnt; we_seen = mem_we; be_seen = mem_byteen;

    e_err = (w >= 0) && !legal(b);
    e_rv0 = (w == 0) && !wr;
    e_rv1 = (w == 1) && !wr;
    if (e_rv0) e_rd0 = shadow[a[7:2]];
    if (e_rv1) e_rd1 = shadow[a[7:2]];
    if (w >= 0 && wr && legal(b))
      for (int i = 0; i < 4; i++) if (b[i]) shadow[a[7:2]][8*i +: 8] = d[8*i +: 8];
    if (w >= 0 && lk && burst + 1 < LOCK_MAX) begin
      owner = w; burst = burst + 1;
    end else begin
      owner = -1; burst = 0;
    end
    if (m1_req && w != 1) waited = (waited < STARVE_LIMIT) ? waited + 1 : waited;
    else                  waited = 0;
    last_w = w;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    set_m(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'b0000);
    set_m(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'b0000);
    step();
  endtask

  task automatic rand_m(input int k, input int req_pct);
    logic [3:0] be;
    be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_tab[$urandom_range(0, 7)];
    set_m(k, 1'($urandom_range(0, 99) < req_pct), 1'($urandom), 1'($urandom_range(0, 2) == 0),
          6'($urandom), $urandom, be);
  endtask

  initial begin
    logic [4:0]  h0_5, h1_5;
    logic [19:0] h0, h1;
    logic [31:0] s, exp;

    reset = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'b0000);
    set_m(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'b0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;

    // Both masters read with no starvation: M0 wins, data next cycle.
    set_m(0, 1'b1, 1'b0, 1'b0, 6'd4, 32'h0, 4'b1111);
    set_m(1, 1'b1, 1'b0, 1'b0, 6'd8, 32'h0, 4'b1111);
    step();
    chk("t1_m0_gnt", 32'(g0_seen), 32'd1);
    chk("t1_m1_gnt", 32'(g1_seen), 32'd0);
    chk("t1_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t1_rdata", m0_rdata, seed(4));
    idle();

    // Starvation promotion after STARVE_LIMIT lost cycles.
    h0_5 = '0; h1_5 = '0;
    set_m(1, 1'b1, 1'b0, 1'b0, 6'd12, 32'h0, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      set_m(0, 1'b1, 1'b0, 1'b0, 6'(c), 32'h0, 4'b1111);
      step();
      h0_5[c] = g0_seen; h1_5[c] = g1_seen;
    end
    chk("t2_m0_hist", 32'(h0_5), 32'h0F);
    chk("t2_m1_hist", 32'(h1_5), 32'h10);
    step();
    chk("t2_wait_cleared", 32'(g0_seen), 32'd1);
    idle();

    // Upper-halfword write by M1, then readback.
    set_m(1, 1'b1, 1'b1, 1'b0, 6'd16, 32'h1234_5678, 4'b1100);
    step();
    chk("t3_byteen", 32'(be_seen), 32'hC);
    chk("t3_we", 32'(we_seen), 32'd1);
    set_m(1, 1'b1, 1'b0, 1'b0, 6'd16, 32'h0, 4'b1111);
    step();
    s = seed(16);
    exp = {16'h1234, s[15:0]};
    chk("t3_readback", m1_rdata, exp);
    idle();

    // Locked burst capped at LOCK_MAX grants; starved M1 takes the release cycle.
    h0 = '0; h1 = '0;
    set_m(1, 1'b1, 1'b0, 1'b0, 6'd20, 32'h0, 4'b1111);
    for (int c = 0; c < 20; c++) begin
      set_m(0, 1'b1, 1'b0, 1'b1, 6'(c + 30), 32'h0, 4'b1111);
      if (last_w == 1) set_m(1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 4'b0000);
      step();
      h0[c] = g0_seen; h1[c] = g1_seen;
    end
    chk("t4_m0_run", 32'(h0[15:0]), 32'hFFFF);
    chk("t4_m0_released", 32'(h0[16]), 32'd0);
    chk("t4_m1_at16", 32'(h1[16]), 32'd1);
    chk("t4_m1_before", 32'(h1[15:0]), 32'd0);
    idle();

    // Illegal byte enables: granted, write suppressed, err next cycle.
    set_m(0, 1'b1, 1'b1, 1'b0, 6'd9, 32'hDEAD_BEEF, 4'b0101);
    step();
    chk("t5_gnt", 32'(g0_seen), 32'd1);
    chk("t5_we", 32'(we_seen), 32'd0);
    chk("t5_err", 32'(err), 32'd1);
    set_m(0, 1'b1, 1'b0, 1'b0, 6'd9, 32'h0, 4'b1111);
    step();
    chk("t5_unchanged", m0_rdata, seed(9));
    idle();

    // Reset during LOCK1 with a read in flight.
    set_m(1, 1'b1, 1'b0, 1'b1, 6'd3, 32'h0, 4'b1111);
    step();
    set_m(0, 1'b1, 1'b0, 1'b0, 6'd1, 32'h0, 4'b1111);
    #1 reset = 1'b0;
    #1;
    chk("t6_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("t6_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("t6_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("t6_m1_rdata", m1_rdata, 32'd0);
    chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_mem_byteen", 32'(mem_byteen), 32'd0);
    chk("t6_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    step();
    chk("t6_idle_arb", 32'(g0_seen), 32'd1);
    idle();

    // Random traffic with masters holding requests until granted.
    for (int c = 0; c < 400; c++) begin
      if (!m0_req || last_w == 0) rand_m(0, 70);
      if (!m1_req || last_w == 1) rand_m(1, 50);
      step();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
